// File: rtl/dmem_responder_if.sv
// dmem_responder_if
// Data request bus between the pipeline memory stage (master) and the
// data-memory responder (slave).
//   dreq   : access request, held by the initiator until dready
//   drw    : 1 = write, 0 = read
//   daddr  : byte address
//   dwdata : store data
//   drdata : read data, valid only with dready
//   dready : one-cycle completion pulse
//   derr   : error flag, valid only with dready
//   busy   : responder is in WAIT or RESP
interface dmem_responder_if;
   logic        dreq;
   logic        drw;
   logic [31:0] daddr;
   logic [31:0] dwdata;
   logic [31:0] drdata;
   logic        dready;
   logic        derr;
   logic        busy;

   modport master (
      output dreq, drw, daddr, dwdata,
      input  drdata, dready, derr, busy
   );

   modport slave (
      input  dreq, drw, daddr, dwdata,
      output drdata, dready, derr, busy
   );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder
// Target end of the toy core's data request interface. Accepts one word
// access at a time, waits WAIT_CYCLES cycles, then performs the array
// access and returns a one-cycle dready pulse with read data / error.
// Ports:
//   clk : clock, all state changes on posedge
//   rst : asynchronous active-high reset
//   bus : dmem_responder_if.slave (dreq/drw/daddr/dwdata in,
//         drdata/dready/derr/busy out, all outputs registered)
// Parameters:
//   DEPTH_LOG2  : log2 of array depth in 32-bit words (4..16)
//   WAIT_CYCLES : wait states between accept and response (0..15)
// Optional feature:
//   DMEM_ALIGN_CHECK_EN : when defined, a byte address with nonzero
//   low two bits is reported as an error and its write is suppressed.
module dmem_responder #(
   parameter int DEPTH_LOG2  = 10,
   parameter int WAIT_CYCLES = 2
) (
   input logic             clk,
   input logic             rst,
   dmem_responder_if.slave bus
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                state;
   logic [3:0]            wait_cnt;
   logic                  lat_rw;
   logic [31:0]           lat_addr;
   logic [31:0]           lat_wdata;

   // Word array; deliberately not cleared by reset.
   logic [31:0]           mem [2**DEPTH_LOG2];

   logic                  fire;
   logic                  acc_rw;
   logic [31:0]           acc_addr;
   logic [31:0]           acc_wdata;
   logic                  acc_err;
   logic [DEPTH_LOG2-1:0] acc_idx;
   logic                  mem_we;

   // The array access happens on the edge that enters RESP. With zero wait
   // states that is the accept edge itself, so the live bus fields are used
   // there; otherwise the copies latched at accept are used.
   always_comb begin
      fire      = 1'b0;
      acc_rw    = lat_rw;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
      if (state == IDLE) begin
         acc_rw    = bus.drw;
         acc_addr  = bus.daddr;
         acc_wdata = bus.dwdata;
         fire      = bus.dreq && (WAIT_CYCLES == 0);
      end else if (state == WAIT) begin
         fire = (wait_cnt == 4'd1);
      end
   end

   // Range error when any address bit above the word index is set.
   always_comb begin
      acc_err = ((acc_addr >> (DEPTH_LOG2 + 2)) != 32'd0);
`ifdef DMEM_ALIGN_CHECK_EN
      if (acc_addr[1:0] != 2'b00) begin
         acc_err = 1'b1;
      end
`endif
      acc_idx = acc_addr[DEPTH_LOG2+1:2];
      mem_we  = fire && acc_rw && !acc_err && !rst;
   end

   // Array write port; errored writes never reach the array.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[acc_idx] <= acc_wdata;
      end
   end

   // Control FSM with registered outputs. Response outputs default to zero
   // every cycle so dready is a single-cycle pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         wait_cnt   <= 4'd0;
         lat_rw     <= 1'b0;
         lat_addr   <= 32'd0;
         lat_wdata  <= 32'd0;
         bus.drdata <= 32'd0;
         bus.dready <= 1'b0;
         bus.derr   <= 1'b0;
         bus.busy   <= 1'b0;
      end else begin
         bus.drdata <= 32'd0;
         bus.dready <= 1'b0;
         bus.derr   <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.dreq) begin
                  lat_rw    <= bus.drw;
                  lat_addr  <= bus.daddr;
                  lat_wdata <= bus.dwdata;
                  wait_cnt  <= 4'(WAIT_CYCLES);
                  bus.busy  <= 1'b1;
                  state     <= (WAIT_CYCLES == 0) ? RESP : WAIT;
               end
            end
            WAIT: begin
               wait_cnt <= wait_cnt - 4'd1;
               if (wait_cnt == 4'd1) begin
                  state <= RESP;
               end
            end
            RESP: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
            end
         endcase
         if (fire) begin
            bus.dready <= 1'b1;
            bus.derr   <= acc_err;
            bus.drdata <= (acc_err || acc_rw) ? 32'd0 : mem[acc_idx];
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
// Self-checking bench for dmem_responder. Instance a uses the default
// WAIT_CYCLES=2, instance b uses WAIT_CYCLES=0 for the streaming case.
// Expected responses are pushed to a queue when a request is driven and
// popped when the responder raises dready.
module tb_dmem_responder;

   logic clk;
   logic rst;
   int   compared;
   int   mismatched;

   dmem_responder_if a_if ();
   dmem_responder_if b_if ();

   dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (a_if)
   );

   dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (b_if)
   );

   // {derr, drdata} expected per response
   logic [32:0] sb_q[$];
   logic [32:0] sb_b_q[$];

   // Reference contents of instance a, keyed by word index.
   logic [31:0] model_a [int];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // One access on instance a through the scoreboard; checks latency,
   // response values and that dready lasts exactly one cycle.
   task automatic access_a(input logic rw, input logic [31:0] addr,
                           input logic [31:0] wdata, input string name);
      logic        err;
      logic [31:0] exp_data;
      logic [32:0] exp;
      int          idx;
      int          edges;
      err = (addr[31:12] != 20'd0);
`ifdef DMEM_ALIGN_CHECK_EN
      if (addr[1:0] != 2'b00) err = 1'b1;
`endif
      idx      = int'(addr[11:2]);
      exp_data = 32'd0;
      if (!err) begin
         if (rw) model_a[idx] = wdata;
         else if (model_a.exists(idx)) exp_data = model_a[idx];
      end
      sb_q.push_back({err, exp_data});

      @(negedge clk);
      a_if.dreq   = 1'b1;
      a_if.drw    = rw;
      a_if.daddr  = addr;
      a_if.dwdata = wdata;
      @(posedge clk);
      #1;
      // Scramble the bus after accept; the latched copies must be used.
      a_if.dreq   = 1'b0;
      a_if.drw    = ~rw;
      a_if.daddr  = $urandom;
      a_if.dwdata = $urandom;
      edges = 0;
      while (a_if.dready !== 1'b1 && edges < 20) begin
         @(posedge clk);
         #1;
         edges++;
      end
      exp = sb_q.pop_front();
      compared++;
      if (edges !== 2) begin
         mismatched++;
         $display("[TB] FAIL %s latency: got %0d edges, want 2", name, edges);
      end
      compared++;
      if (a_if.drdata !== exp[31:0]) begin
         mismatched++;
         $display("[TB] FAIL %s drdata: got %h, want %h", name, a_if.drdata, exp[31:0]);
      end
      compared++;
      if (a_if.derr !== exp[32]) begin
         mismatched++;
         $display("[TB] FAIL %s derr: got %b, want %b", name, a_if.derr, exp[32]);
      end
      compared++;
      if (a_if.busy !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL %s busy_resp: got %b, want 1", name, a_if.busy);
      end
      @(posedge clk);
      #1;
      compared++;
      if (a_if.dready !== 1'b0 || a_if.busy !== 1'b0 || a_if.derr !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL %s after_pulse: dready=%b busy=%b derr=%b, want 0 0 0",
                  name, a_if.dready, a_if.busy, a_if.derr);
      end
   endtask

   task automatic test_reset();
      int edges;
      rst = 1'b1;
      #1;
      compared++;
      if ({a_if.dready, a_if.derr, a_if.busy, a_if.drdata} !== 35'd0) begin
         mismatched++;
         $display("[TB] FAIL reset_a: dready=%b derr=%b busy=%b drdata=%h, want all 0",
                  a_if.dready, a_if.derr, a_if.busy, a_if.drdata);
      end
      compared++;
      if ({b_if.dready, b_if.derr, b_if.busy, b_if.drdata} !== 35'd0) begin
         mismatched++;
         $display("[TB] FAIL reset_b: dready=%b derr=%b busy=%b drdata=%h, want all 0",
                  b_if.dready, b_if.derr, b_if.busy, b_if.drdata);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Out-of-range read so the response carries derr=1, then reset in RESP.
      @(negedge clk);
      a_if.dreq  = 1'b1;
      a_if.drw   = 1'b0;
      a_if.daddr = 32'h0001_0000;
      @(posedge clk);
      #1;
      a_if.dreq = 1'b0;
      edges = 0;
      while (a_if.dready !== 1'b1 && edges < 20) begin
         @(posedge clk);
         #1;
         edges++;
      end
      compared++;
      if (a_if.dready !== 1'b1 || a_if.derr !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL reset_pre_resp: dready=%b derr=%b, want 1 1",
                  a_if.dready, a_if.derr);
      end
      #2;
      rst = 1'b1;
      #1;
      compared++;
      if ({a_if.dready, a_if.derr, a_if.busy, a_if.drdata} !== 35'd0) begin
         mismatched++;
         $display("[TB] FAIL reset_async: dready=%b derr=%b busy=%b drdata=%h, want all 0",
                  a_if.dready, a_if.derr, a_if.busy, a_if.drdata);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      compared++;
      if (a_if.busy !== 1'b0 || a_if.dready !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_idle: busy=%b dready=%b, want 0 0", a_if.busy, a_if.dready);
      end
   endtask

   task automatic test_write_read();
      access_a(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, "wr_40");
      access_a(1'b0, 32'h0000_0040, 32'h0, "rd_40");
      access_a(1'b1, 32'h0000_0ffc, 32'h0BAD_CAFE, "wr_top");
      access_a(1'b0, 32'h0000_0ffc, 32'h0, "rd_top");
      access_a(1'b0, 32'h0000_0040, 32'h0, "rd_40_again");
   endtask

   // Instance b, dreq held high for 6 cycles per pass: writes then reads.
   task automatic test_back_to_back();
      logic [31:0] addrs [3];
      logic [31:0] wdat  [3];
      logic [31:0] rexp  [3];
      logic [32:0] exp;
      int          n;
      int          pulses;
      addrs = '{32'h0, 32'h4, 32'h0};
      wdat  = '{32'h1111_0000, 32'h2222_0000, 32'h3333_0000};
      rexp  = '{32'h3333_0000, 32'h2222_0000, 32'h3333_0000};
      for (int pass = 0; pass < 2; pass++) begin
         n      = 0;
         pulses = 0;
         @(negedge clk);
         b_if.drw    = (pass == 0);
         b_if.daddr  = addrs[0];
         b_if.dwdata = wdat[0];
         b_if.dreq   = 1'b1;
         sb_b_q.push_back((pass == 0) ? 33'd0 : {1'b0, rexp[0]});
         for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            compared++;
            if (b_if.dready !== 1'(i % 2 == 0)) begin
               mismatched++;
               $display("[TB] FAIL b2b_pattern pass%0d cycle%0d: dready=%b, want %b",
                        pass, i, b_if.dready, 1'(i % 2 == 0));
            end
            if (b_if.dready === 1'b1 && sb_b_q.size() > 0) begin
               exp = sb_b_q.pop_front();
               compared++;
               if (b_if.drdata !== exp[31:0] || b_if.derr !== exp[32]) begin
                  mismatched++;
                  $display("[TB] FAIL b2b_data pass%0d n%0d: drdata=%h derr=%b, want %h %b",
                           pass, n, b_if.drdata, b_if.derr, exp[31:0], exp[32]);
               end
               pulses++;
               n++;
               if (n < 3) begin
                  b_if.daddr  = addrs[n];
                  b_if.dwdata = wdat[n];
                  sb_b_q.push_back((pass == 0) ? 33'd0 : {1'b0, rexp[n]});
               end
            end
         end
         b_if.dreq = 1'b0;
         compared++;
         if (pulses !== 3) begin
            mismatched++;
            $display("[TB] FAIL b2b_count pass%0d: got %0d pulses, want 3", pass, pulses);
         end
         sb_b_q.delete();
      end
   endtask

   task automatic test_range_error();
      access_a(1'b1, 32'h0000_0000, 32'hCAFE_F00D, "wr_0");
      access_a(1'b1, 32'h0000_1000, 32'h1234_5678, "wr_range");
      access_a(1'b0, 32'h0000_0000, 32'h0, "rd_0_after_range");
      access_a(1'b0, 32'h8000_0040, 32'h0, "rd_range");
   endtask

   task automatic test_reset_abort();
      int edges;
      int seen;
      access_a(1'b1, 32'h0000_0008, 32'h0102_0304, "wr_8_old");
      @(negedge clk);
      a_if.dreq   = 1'b1;
      a_if.drw    = 1'b1;
      a_if.daddr  = 32'h0000_0008;
      a_if.dwdata = 32'hAAAA_5555;
      @(posedge clk);
      #1;
      a_if.dreq = 1'b0;
      compared++;
      if (a_if.busy !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL abort_busy: got %b, want 1", a_if.busy);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      compared++;
      if (a_if.busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL abort_async_busy: got %b, want 0", a_if.busy);
      end
      @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      for (edges = 0; edges < 6; edges++) begin
         @(negedge clk);
         if (a_if.dready === 1'b1) seen++;
      end
      compared++;
      if (seen !== 0) begin
         mismatched++;
         $display("[TB] FAIL abort_no_dready: got %0d pulses, want 0", seen);
      end
      access_a(1'b0, 32'h0000_0008, 32'h0, "rd_8_after_abort");
   endtask

   task automatic test_align();
      access_a(1'b1, 32'h0000_0040, 32'h0000_0099, "wr_40_pre");
      access_a(1'b1, 32'h0000_0042, 32'h0000_0011, "wr_42");
      access_a(1'b0, 32'h0000_0040, 32'h0, "rd_40_align");
   endtask

   initial begin
      compared    = 0;
      mismatched  = 0;
      rst         = 1'b1;
      a_if.dreq   = 1'b0;
      a_if.drw    = 1'b0;
      a_if.daddr  = 32'd0;
      a_if.dwdata = 32'd0;
      b_if.dreq   = 1'b0;
      b_if.drw    = 1'b0;
      b_if.daddr  = 32'd0;
      b_if.dwdata = 32'd0;
      $display("[TB] start");
      test_reset();
      test_write_read();
      test_back_to_back();
      test_range_error();
      test_reset_abort();
      test_align();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
